// File: rtl/phy_pkg.sv
// Shared PHY definitions: comma symbol, lock threshold and receiver state encoding.
package phy_pkg;

  localparam logic [7:0]  COM            = 8'hBC;
  localparam int unsigned COM_LOCK_COUNT = 4;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } rx_state_t;

endpackage : phy_pkg

// File: rtl/serial_parallel_rx.sv
// Serial-to-parallel receiver: finds byte alignment from repeated COM symbols, then emits bytes.
// Build option: define IDLE_FILTER_EN to suppress valid_out for COM bytes received while ACTIVE.
module serial_parallel_rx
  import phy_pkg::*;
(
  input  logic       clk32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [2:0] LAST_COM = 3'(COM_LOCK_COUNT - 1);

  rx_state_t  state, state_d;
  logic [7:0] sr;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [2:0] com_cnt, com_cnt_d;
  logic       is_com;
  logic       boundary;
  logic       load_byte;
  logic       valid_d;

  assign is_com   = (sr == COM);
  assign boundary = (bit_cnt == 3'd0);

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      state <= HUNT;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so ordering between blocks cannot matter.
      state <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an assignment would otherwise infer a latch.
    state_d   = state;
    com_cnt_d = com_cnt;
    bit_cnt_d = bit_cnt + 3'd1;
    load_byte = 1'b0;
    valid_d   = 1'b0;

    unique case (state)
      HUNT: begin
        // The cycle COM is first seen is a boundary, so the counter restarts one past it.
        bit_cnt_d = 3'd0;
        if (is_com) begin
          state_d   = LOCKING;
          com_cnt_d = 3'd1;
          bit_cnt_d = 3'd1;
        end
      end

      LOCKING: begin
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_cnt + 3'd1;
            if (com_cnt == LAST_COM) begin
              state_d = ACTIVE;
            end
          end else begin
            state_d   = HUNT;
            com_cnt_d = 3'd0;
          end
        end
      end

      ACTIVE: begin
        // Alignment is frozen here; off-boundary COM patterns are just payload bits.
        if (boundary) begin
          load_byte = 1'b1;
`ifdef IDLE_FILTER_EN
          valid_d   = !is_com;
`else
          valid_d   = 1'b1;
`endif
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      sr        <= 8'h00;
      bit_cnt   <= 3'd0;
      com_cnt   <= 3'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr        <= {sr[6:0], data_in};
      bit_cnt   <= bit_cnt_d;
      com_cnt   <= com_cnt_d;
      valid_out <= valid_d;
      active    <= (state_d == ACTIVE);
      if (load_byte) begin
        data_out <= sr;
      end
    end
  end

endmodule : serial_parallel_rx

// File: tb/tb_serial_parallel_rx.sv
// Directed bench for serial_parallel_rx: expected bytes are queued as they are sent and
// popped whenever the receiver strobes valid_out.
`timescale 1ns/1ps
module tb_serial_parallel_rx;
  import phy_pkg::*;

`ifdef IDLE_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic       clk32f  = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_byte = 8'h00;
  logic [7:0] mon_exp;

  serial_parallel_rx dut (
    .clk32f   (clk32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  always #5 clk32f = ~clk32f;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest queued byte.
  always @(negedge clk32f) begin
    if (valid_out !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {7'd0, valid_out}, 8'h00);
      end else begin
        mon_exp = exp_q.pop_front();
        check("data_out", data_out, mon_exp);
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk32f);
    data_in = b;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit locked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    if (locked) begin
      last_byte = b;
      if (!(FILTER && b == COM)) exp_q.push_back(b);
    end
  endtask

  task automatic send_lock();
    repeat (4) send_byte(COM, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},   data_out,           8'h00);
    check({tag, "_valid"},  {7'd0, valid_out},  8'h00);
    check({tag, "_active"}, {7'd0, active},     8'h00);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk32f);
    reset   = 1'b0;
    data_in = 1'b0;
    #1;
    check_zero("reset");
    repeat (cycles) @(negedge clk32f);
    reset = 1'b1;
    exp_q.delete();
    last_byte = 8'h00;
  endtask

  // Two spare bits let the last strobe reach the monitor without completing another byte.
  task automatic drain(input string tag);
    repeat (2) send_bit(1'b0);
    #1;
    check({tag, "_queue_empty"}, 8'(exp_q.size()), 8'h00);
    check({tag, "_data_hold"},   data_out,         last_byte);
  endtask

  initial begin
    // Basic lock then one payload byte, with active edge timing.
    do_reset(10);
    send_lock();
    #7;
    check("active_at_4th_com", {7'd0, active}, 8'h00);
    send_bit(1'b1);
    #7;
    check("active_rise", {7'd0, active}, 8'h01);
    for (int i = 6; i >= 0; i--) send_bit(1'b1);
    last_byte = 8'hFF;
    exp_q.push_back(8'hFF);
    drain("ff");

    // Lock at a non-zero bit offset.
    do_reset(3);
    repeat (3) send_bit(1'($urandom_range(0, 1)));
    send_lock();
    send_byte(8'hEE, 1'b1);
    send_byte(8'hDD, 1'b1);
    drain("offset3");
    check("offset3_active", {7'd0, active}, 8'h01);

    // A non-COM boundary during locking drops back to HUNT.
    do_reset(3);
    send_byte(COM, 1'b0);
    send_byte(COM, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(COM, 1'b0);
    check("state_after_55", {6'd0, dut.state}, {6'd0, HUNT});
    send_byte(COM, 1'b0);
    send_byte(COM, 1'b0);
    #7;
    check("active_3_after_relock", {7'd0, active}, 8'h00);
    send_byte(COM, 1'b0);
    #7;
    check("active_at_4th_relock", {7'd0, active}, 8'h00);
    send_byte(8'h81, 1'b1);
    check("active_after_relock", {7'd0, active}, 8'h01);
    drain("relock");

    // COM bytes inside the locked stream.
    do_reset(3);
    send_lock();
    send_byte(COM,   1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(COM,   1'b1);
    drain("idle");

    // Asynchronous reset in the middle of a byte, then relock.
    do_reset(3);
    send_lock();
    send_byte(8'hA5, 1'b1);
    repeat (3) send_bit(1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_zero("midbyte_reset");
    check("midbyte_state", {6'd0, dut.state}, {6'd0, HUNT});
    check("midbyte_queue", 8'(exp_q.size()), 8'h00);
    repeat (2) @(negedge clk32f);
    reset     = 1'b1;
    data_in   = 1'b0;
    last_byte = 8'h00;
    send_lock();
    send_byte(8'h3C, 1'b1);
    drain("after_reset");

    // A COM pattern straddling two bytes must not move the boundary.
    do_reset(3);
    send_lock();
    send_byte(8'h0B, 1'b1);
    send_byte(8'hC0, 1'b1);
    send_byte(8'h12, 1'b1);
    drain("shifted_com");
    check("shifted_com_active", {7'd0, active}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_parallel_rx

// File: doc/serial_parallel_rx.md
SERIAL_PARALLEL_RX -- requirements
Module: serial_parallel_rx

Interface
REQ-001 clk32f  input  1  Single clock, serial bit rate; all state changes on its rising edge.
REQ-002 reset  input  1  Asynchronous, active-low reset (0 = in reset); deassertion is synchronous to clk32f.
REQ-003 data_in  input  1  Serial lane bit, MSB of each byte first, sampled every clk32f rising edge.
REQ-004 data_out  output  8  Last recovered byte, registered.
REQ-005 valid_out  output  1  One-cycle strobe; data_out holds a valid payload byte in that cycle.
REQ-006 active  output  1  High while the receiver is byte-locked (ACTIVE state).

Function
REQ-007 Shift register sr[7:0] SHALL update every cycle as sr <= {sr[6:0], data_in}, in all states.
REQ-008 FSM states SHALL be HUNT, LOCKING and ACTIVE; HUNT is the reset state.
REQ-009 HUNT: on the first cycle sr == COM (8'hBC) at any bit offset, the FSM SHALL go to LOCKING, set com_cnt = 1 and mark this cycle as a byte boundary.
REQ-010 Byte boundaries SHALL then recur every 8 clk32f cycles, tracked by a 3-bit bit counter that wraps 7 -> 0.
REQ-011 LOCKING: at each boundary, sr == COM SHALL increment com_cnt; any other value SHALL return the FSM to HUNT with com_cnt = 0.
REQ-012 LOCKING: com_cnt reaching 4 (COM_LOCK_COUNT) SHALL move the FSM to ACTIVE, with the alignment kept.
REQ-013 LOCKING: sr == COM at a non-boundary cycle SHALL be ignored.
REQ-014 ACTIVE: at each boundary, data_out SHALL load sr on the next clock edge (latency 1 cycle after the last bit of the byte is sampled).
REQ-015 ACTIVE: valid_out for that byte SHALL follow REQ-021/REQ-022.
REQ-016 valid_out SHALL be 0 outside boundary+1 cycles and in HUNT and LOCKING.
REQ-017 data_out SHALL hold its last value between boundaries.
REQ-018 ACTIVE SHALL persist until reset; misaligned COM patterns SHALL NOT cause realignment.
REQ-019 active SHALL be registered and equal 1 exactly while the state is ACTIVE.

Reset
REQ-020 reset == 0 SHALL immediately force the following, even mid-byte:
- state = HUNT
- sr = 0, bit counter = 0, com_cnt = 0
- data_out = 8'h00, valid_out = 0, active = 0

Configuration
REQ-021 With IDLE_FILTER_EN defined, COM bytes received in ACTIVE SHALL update data_out with valid_out = 0 (idle suppressed); non-COM bytes SHALL pulse valid_out = 1.
REQ-022 Without IDLE_FILTER_EN, every byte received in ACTIVE, COM included, SHALL pulse valid_out = 1.

Structure
REQ-023 Shared package phy_pkg SHALL hold:
- COM symbol constant (8'hBC)
- COM_LOCK_COUNT (4)
- rx state enumeration (HUNT, LOCKING, ACTIVE)
REQ-024 The block SHALL be a single module with no sub-modules; the shift/detect and FSM logic are too small to split.

Verification
REQ-025 Reset held low 10 cycles, then 4 x 8'hBC and 8'hFF serialized -> the following:
- active rises one cycle after the 4th COM boundary
- data_out = 8'hFF with valid_out = 1 one cycle after its 8th bit
REQ-026 3 random bits, then 4 x 8'hBC, 8'hEE, 8'hDD -> lock at offset 3; data_out sequence 8'hEE, 8'hDD, each with a single-cycle valid_out.
REQ-027 8'hBC, 8'hBC, 8'h55, then 4 x 8'hBC -> return to HUNT at the 8'h55 boundary; active = 0 until the later 4th COM.
REQ-028 Locked stream 8'hBC, 8'hAA, 8'hBC -> with IDLE_FILTER_EN only 8'hAA strobes valid_out; without it, three strobes with data 8'hBC, 8'hAA, 8'hBC.
REQ-029 reset pulsed low mid-byte while ACTIVE -> all outputs 0 immediately, state HUNT; relock after 4 new COMs.
REQ-030 ACTIVE, then a stream containing 8'hBC at a shifted offset -> no realignment; data_out continues at the original boundary.
